// File: rtl/delay_tap_ctrl.sv
// Selectable-tap delay line (0..3 accepted samples) with a guarded tap switch.
// Optional macro DELAY_TAP_CTRL_STATS_EN adds the out_cnt valid-output counter.
module delay_tap_ctrl #(
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       flush,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_tap,
  output logic       cfg_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] tap_cur,
  output logic       busy,
`ifdef DELAY_TAP_CTRL_STATS_EN
  output logic [15:0] out_cnt,
`endif
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_LD = 4'(GUARD - 1);

  state_t     r_state;
  logic [1:0] r_tap;
  logic [3:0] r_guard;
  logic       r_busy;
  logic       r_cfg_ready;
  logic [7:0] r_s1, r_s2, r_s3;
  logic [2:0] r_v;            // r_v[0]=v1, r_v[1]=v2, r_v[2]=v3
  logic       w_cfg_acc;
  logic       w_out_valid;
  logic [7:0] w_out_data;

  // Handshake: a cfg transfer happens on any rising edge where cfg_valid and
  // cfg_ready are both high; cfg_tap is sampled on that edge only.
  assign w_cfg_acc = cfg_valid & r_cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tap       <= 2'd0;
      r_guard     <= 4'd0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cfg_acc) begin
            r_tap       <= cfg_tap;
            r_guard     <= GUARD_LD;
            r_state     <= SWITCH;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
          end
        end
        SWITCH: begin
          if (r_guard == 4'd0) begin
            r_state     <= RUN;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else begin
            r_guard <= r_guard - 4'd1;
          end
        end
        RUN: begin
          // A same-tap request is still accepted but leaves the FSM in RUN.
          if (w_cfg_acc && (cfg_tap != r_tap)) begin
            r_tap       <= cfg_tap;
            r_guard     <= GUARD_LD;
            r_state     <= SWITCH;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 8'd0;
      r_s2 <= 8'd0;
      r_s3 <= 8'd0;
      r_v  <= 3'b000;
    end else if (in_valid) begin
      r_s1 <= in_data;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_v  <= flush ? 3'b001 : {r_v[1:0], 1'b1};
    end else if (flush) begin
      r_v <= 3'b000;
    end
  end

  // Output path is combinational so tap 0 has zero latency.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = 8'd0;
    if (r_state == RUN) begin
      case (r_tap)
        2'd0: begin
          w_out_valid = in_valid;
          w_out_data  = in_data;
        end
        2'd1: begin
          w_out_valid = in_valid & r_v[0];
          w_out_data  = r_s1;
        end
        2'd2: begin
          w_out_valid = in_valid & r_v[1];
          w_out_data  = r_s2;
        end
        default: begin
          w_out_valid = in_valid & r_v[2];
          w_out_data  = r_s3;
        end
      endcase
    end
  end

  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign tap_cur   = r_tap;
  assign busy      = r_busy;
  assign cfg_ready = r_cfg_ready;
  assign dbg_state = r_state;

`ifdef DELAY_TAP_CTRL_STATS_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (w_cfg_acc) begin
      r_cnt <= 16'd0;
    end else if (w_out_valid && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign out_cnt = r_cnt;
`endif

endmodule

// File: doc/delay_tap_ctrl.md
DELAY_TAP_CTRL -- requirements
Module: delay_tap_ctrl

Interface
REQ-001 Parameter: GUARD, default 2, number of cycles out_valid is held low after a tap change (1..15).
REQ-002 Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data carries a sample this cycle.
- in_data  input  8  sample data.
- flush  input  1  invalidate delay-line history.
- cfg_valid  input  1  tap-change request.
- cfg_tap  input  2  requested tap: 0 = no delay, 1..3 = delay of that many accepted samples.
- cfg_ready  output  1  request accepted when cfg_valid and cfg_ready are both high.
- out_valid  output  1  out_data is a valid delayed sample this cycle.
- out_data  output  8  selected tap data.
- tap_cur  output  2  tap currently in effect.
- busy  output  1  high in SWITCH.

Function
REQ-003 The block SHALL hold three 8-bit stages s1..s3 and three valid bits v1..v3.
REQ-004 On in_valid=1 the stages SHALL advance: s1<=in_data, s2<=s1, s3<=s2, v1<=1, v2<=v1, v3<=v2.
REQ-005 On in_valid=0 the stages SHALL hold (stall); there is no timeout.
REQ-006 FSM states SHALL be IDLE, SWITCH and RUN; reset enters IDLE.
REQ-007 IDLE: the delay line still shifts per REQ-004; out_valid=0; out_data=0; cfg_ready=1.
REQ-008 An accepted cfg in IDLE SHALL load tap_cur<=cfg_tap and go to SWITCH.
REQ-009 SWITCH: a 4-bit guard counter loads GUARD-1 on entry and decrements every cycle.
REQ-010 SWITCH: cfg_ready=0, out_valid=0, busy=1; the FSM goes to RUN when the counter reaches 0 (exactly GUARD cycles in SWITCH).
REQ-011 RUN with tap_cur=0: out_data=in_data and out_valid=in_valid, combinationally (zero latency).
REQ-012 RUN with tap_cur=k (1..3): out_data=s_k and out_valid=in_valid & v_k, combinationally.
REQ-013 With tap_cur=k, exactly one output is produced per accepted input, namely the sample accepted k inputs earlier.
REQ-014 RUN: cfg_ready=1. An accepted cfg with cfg_tap != tap_cur SHALL load tap_cur and go to SWITCH.
REQ-015 RUN: an accepted cfg with cfg_tap == tap_cur SHALL be accepted with no state change.
REQ-016 Simultaneous cfg acceptance and in_valid: shifting occurs, and that cycle's output uses the old tap_cur.
REQ-017 flush=1 SHALL clear v1..v3 next cycle; s1..s3 are not cleared.
REQ-018 flush with in_valid in the same cycle: v1<=1, v2<=0, v3<=0, and data shifts normally.
REQ-019 flush SHALL NOT change FSM state or tap_cur.
REQ-020 out_valid and out_data SHALL be undefined-free: out_data=0 whenever the FSM is not in RUN.

Reset
REQ-021 rst=1 SHALL asynchronously clear s1..s3, v1..v3, tap_cur, the guard counter and the FSM (to IDLE).
REQ-022 Output values during and after reset: out_valid=0, out_data=0, tap_cur=0, busy=0, cfg_ready=1.
REQ-023 Reset asserted mid-SWITCH or mid-stream SHALL discard all history; no stale out_valid occurs after release.

Configuration
REQ-024 Macro DELAY_TAP_CTRL_STATS_EN defined: the block SHALL add output out_cnt[15:0].
REQ-025 out_cnt behaviour: counts cycles with out_valid=1, saturates at 16'hFFFF, and is cleared by rst and by each accepted cfg.
REQ-026 Macro DELAY_TAP_CTRL_STATS_EN undefined: out_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset then cfg_tap=2 accepted, GUARD=2:
- busy=1 for 2 cycles, then RUN.
- Feed 8'h11, 22, 33, 44 on consecutive cycles: out_valid first asserts with in_data=33 and out_data=11, then 44->22.
REQ-028 tap 3, feed 8'hA0..A5 with in_valid gaps of 1 and 3 cycles:
- Outputs are A0, A1, A2, each only in in_valid cycles.
- Stalls do not lose or duplicate samples.
REQ-029 tap 1 in RUN, assert flush together with in_valid=1, data 8'h55:
- That cycle's output is the old s1.
- The next in_valid (8'h66) yields out_data=55, valid.
- A tap-2 request after this yields no valid output until two new samples have been accepted.
REQ-030 cfg_valid in SWITCH is not accepted (cfg_ready=0); it is accepted on the first RUN cycle.
REQ-031 Same-tap cfg in RUN: no SWITCH and no out_valid gap.
REQ-032 rst asserted mid-SWITCH with v3=1: all outputs clear immediately; after release, tap_cur=0 and out_valid=0.
- With DELAY_TAP_CTRL_STATS_EN, 5 valid outputs give out_cnt=5, and a following cfg clears it to 0.
